// File: rtl/rr_flow_arb_if.sv
// rr_flow_arb_if: bundle of the arbiter's requester and downstream signals.
//   valid_in/last_in/d_in : M requester streams (d_in lane i at [i*N +: N])
//   ready_out             : per-requester accept, at most one bit set
//   valid_out/last_out/d_out/src_out : registered output beat
//   ready_in              : downstream ready
// master = producers + downstream sink (testbench side), slave = arbiter.
interface rr_flow_arb_if #(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int IDW = $clog2(M)
);
    logic [M-1:0]   valid_in;
    logic [M-1:0]   last_in;
    logic [M*N-1:0] d_in;
    logic [M-1:0]   ready_out;
    logic           valid_out;
    logic           last_out;
    logic [N-1:0]   d_out;
    logic [IDW-1:0] src_out;
    logic           ready_in;

    modport master (
        output valid_in, last_in, d_in, ready_in,
        input  ready_out, valid_out, last_out, d_out, src_out
    );

    modport slave (
        input  valid_in, last_in, d_in, ready_in,
        output ready_out, valid_out, last_out, d_out, src_out
    );
endinterface

// File: rtl/rr_flow_arb.sv
// rr_flow_arb: packet-aware round-robin arbiter sharing one valid/ready
// output stage between M requesters.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : rr_flow_arb_if.slave (requester inputs, ready_out, registered
//         output beat valid_out/last_out/d_out/src_out, downstream ready_in)
// A grant opened by a non-last beat stays locked to that requester until its
// last beat is accepted. The output register refills in the same cycle it
// drains, giving one beat per cycle.
module rr_flow_arb #(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int IDW = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    rr_flow_arb_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           valid_q;
    logic           last_q;
    logic [N-1:0]   d_q;
    logic [IDW-1:0] src_q;

    logic           load;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic           accept;
    logic [N-1:0]   sel_d;
    logic           sel_last;

    // Stage can take a new beat when empty or draining this cycle.
    assign load = ~valid_q | bus.ready_in;

    // Grant selection. In IDLE the search starts at ptr and wraps; the
    // index is formed one bit wider so ptr+k cannot overflow before the
    // modulo-M correction (M need not be a power of two).
    always_comb begin
        logic [IDW:0] idx;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        if (state_q == LOCKED) begin
            gnt_vld = bus.valid_in[lock_id_q];
            gnt_id  = lock_id_q;
        end else begin
            for (int k = M - 1; k >= 0; k--) begin
                idx = {1'b0, ptr_q} + (IDW+1)'(k);
                if (idx >= (IDW+1)'(M))
                    idx = idx - (IDW+1)'(M);
                // Descending scan so the lowest offset from ptr wins last.
                if (bus.valid_in[idx[IDW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx[IDW-1:0];
                end
            end
        end
    end

    assign accept = gnt_vld & load & ~rst;

    always_comb begin
        bus.ready_out = '0;
        if (accept)
            bus.ready_out[gnt_id] = 1'b1;
    end

    // Data/last mux for the granted lane.
    always_comb begin
        sel_d    = '0;
        sel_last = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_d    = bus.d_in[i*N +: N];
                sel_last = bus.last_in[i];
            end
        end
    end

    // Lock FSM and round-robin pointer, both advanced only by accepted beats.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!sel_last) begin
                        state_d   = LOCKED;
                        lock_id_d = gnt_id;
                    end
                end
                LOCKED: begin
                    if (sel_last)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (sel_last)
                ptr_d = (gnt_id == IDW'(M - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
        end
    end

    // Output stage. An empty load slot clears valid but leaves the payload
    // registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            d_q     <= '0;
            src_q   <= '0;
        end else if (load) begin
            valid_q <= accept;
            if (accept) begin
                last_q <= sel_last;
                d_q    <= sel_d;
                src_q  <= gnt_id;
            end
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.d_out     = d_q;
    assign bus.src_out   = src_q;
endmodule

// File: tb/tb_rr_flow_arb.sv
// Directed bench for rr_flow_arb (M=4, N=4). Inputs change 1 time unit after
// each rising edge; ready_out is probed after a further settle delay, the
// registered outputs reflect the preceding edge.
module tb_rr_flow_arb;
    localparam int M   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_flow_arb_if #(.M(M), .N(N), .IDW(IDW)) bus ();

    rr_flow_arb #(.M(M), .N(N), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [M-1:0] exp_v);
        #1;
        chk(tag, 32'(bus.ready_out), 32'(exp_v));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic l,
                           input logic [N-1:0] d, input logic [IDW-1:0] s);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
        chk({tag, ".last"},  32'(bus.last_out),  32'(l));
        chk({tag, ".d"},     32'(bus.d_out),     32'(d));
        chk({tag, ".src"},   32'(bus.src_out),   32'(s));
    endtask

    initial begin
        // 1. reset with all requesters valid
        rst          = 1'b1;
        bus.valid_in = 4'b1111;
        bus.last_in  = 4'b1111;
        bus.d_in     = 16'hBA98;
        bus.ready_in = 1'b1;
        tick;
        chk_rdy("rst_rdy0", 4'b0000);
        tick;
        chk_rdy("rst_rdy1", 4'b0000);
        chk_out("rst", 1'b0, 1'b0, 4'h0, 2'd0);
        rst = 1'b0;
        chk_rdy("rel_rdy", 4'b0001);
        tick;
        chk_out("rel", 1'b1, 1'b1, 4'h8, 2'd0);

        // 2. round-robin over single-beat packets
        for (int k = 1; k <= 5; k++) begin
            chk_rdy("rr_rdy", 4'(1 << (k % 4)));
            tick;
            chk_out("rr", 1'b1, 1'b1, 4'(8 + k % 4), 2'(k % 4));
        end

        // 3. packet lock on req1 with a bubble; req2 waits
        rst = 1'b1;
        tick;
        rst          = 1'b0;
        bus.valid_in = 4'b0110;
        bus.last_in  = 4'b0100;
        bus.d_in     = 16'h0C50;
        chk_rdy("lk_rdy5", 4'b0010);
        tick;
        chk_out("lk5", 1'b1, 1'b0, 4'h5, 2'd1);
        bus.d_in = 16'h0C60;
        chk_rdy("lk_rdy6", 4'b0010);
        tick;
        chk_out("lk6", 1'b1, 1'b0, 4'h6, 2'd1);
        bus.valid_in = 4'b0100;
        chk_rdy("lk_gap_rdy", 4'b0000);
        tick;
        chk_out("lk_gap", 1'b0, 1'b0, 4'h6, 2'd1);
        bus.valid_in = 4'b0110;
        bus.last_in  = 4'b0110;
        bus.d_in     = 16'h0C70;
        chk_rdy("lk_rdy7", 4'b0010);
        tick;
        chk_out("lk7", 1'b1, 1'b1, 4'h7, 2'd1);
        bus.valid_in = 4'b0100;
        chk_rdy("lk_rdyC", 4'b0100);
        tick;
        chk_out("lkC", 1'b1, 1'b1, 4'hC, 2'd2);

        // 4. backpressure hold, then same-cycle refill
        bus.valid_in = 4'b1111;
        bus.last_in  = 4'b1111;
        bus.d_in     = 16'h3210;
        chk_rdy("bp_rdy", 4'b1000);
        tick;
        chk_out("bp_load", 1'b1, 1'b1, 4'h3, 2'd3);
        bus.ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_rdy("bp_hold_rdy", 4'b0000);
            tick;
            chk_out("bp_hold", 1'b1, 1'b1, 4'h3, 2'd3);
        end
        bus.ready_in = 1'b1;
        chk_rdy("bp_refill_rdy", 4'b0001);
        tick;
        chk_out("bp_refill", 1'b1, 1'b1, 4'h0, 2'd0);

        // 5. reset in the middle of a req0 packet
        bus.valid_in = 4'b0001;
        bus.last_in  = 4'b0000;
        bus.d_in     = 16'h0005;
        chk_rdy("mr_rdy_a", 4'b0001);
        tick;
        chk_out("mr_a", 1'b1, 1'b0, 4'h5, 2'd0);
        chk_rdy("mr_rdy_b", 4'b0001);
        tick;
        chk_out("mr_b", 1'b1, 1'b0, 4'h5, 2'd0);
        rst          = 1'b1;
        bus.valid_in = 4'b1001;
        chk_rdy("mr_rst_rdy", 4'b0000);
        tick;
        chk_out("mr_rst", 1'b0, 1'b0, 4'h0, 2'd0);
        rst          = 1'b0;
        bus.valid_in = 4'b1000;
        bus.last_in  = 4'b1001;
        bus.d_in     = 16'hE007;
        chk_rdy("mr_nolock_rdy", 4'b1000);
        bus.valid_in = 4'b1001;
        chk_rdy("mr_rdy0", 4'b0001);
        tick;
        chk_out("mr_0", 1'b1, 1'b1, 4'h7, 2'd0);
        chk_rdy("mr_rdy3", 4'b1000);
        tick;
        chk_out("mr_3", 1'b1, 1'b1, 4'hE, 2'd3);

        // 6. req3 alone back-to-back, then pointer wrap to req0
        bus.valid_in = 4'b1000;
        bus.last_in  = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            bus.d_in = 16'(k) << 12;
            chk_rdy("wr_rdy", 4'b1000);
            tick;
            chk_out("wr", 1'b1, 1'b1, 4'(k), 2'd3);
        end
        bus.valid_in = 4'b0101;
        bus.last_in  = 4'b0101;
        bus.d_in     = 16'h0201;
        chk_rdy("wrap_rdy0", 4'b0001);
        tick;
        chk_out("wrap_0", 1'b1, 1'b1, 4'h1, 2'd0);
        chk_rdy("wrap_rdy2", 4'b0100);
        tick;
        chk_out("wrap_2", 1'b1, 1'b1, 4'h2, 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
